// File: rtl/act_load_ctrl.sv
// Streams a block of activation words from SRAM into the L0 buffer, with credit-based read issue.
// Define ACT_LOAD_CHECKSUM_EN to build the running XOR checksum of written words.
module act_load_ctrl #(
  parameter int BW     = 4,
  parameter int ROW    = 8,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 12,
  localparam int W     = BW * ROW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [W-1:0]      sram_q,
  output logic              l0_wr,
  output logic [W-1:0]      l0_in,
  input  logic              l0_full,
  output logic [W-1:0]      checksum
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_r;
  logic [CNT_W-1:0]  cnt_r, issued, written;
  logic              inflight, issue;
  logic [1:0]        occ;
  logic [W-1:0]      skid0, skid1;
  logic [2:0]        credit;
  logic [CNT_W:0]    written_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Completion counts this cycle's write so done lands right after the last l0_wr.
  always_comb begin
    state_next  = state;
    written_sum = {1'b0, written} + {{CNT_W{1'b0}}, l0_wr};
    case (state)
      IDLE:  if (start) state_next = (count == '0) ? DONE : RUN;
      RUN:   if (abort) state_next = IDLE;
             else if (issue && (issued + CNT_W'(1) == cnt_r)) state_next = DRAIN;
      DRAIN: if (abort) state_next = IDLE;
             else if (!inflight && (written_sum == {1'b0, cnt_r})) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
    l0_wr    = (occ != 2'd0) && !l0_full;
    l0_in    = (occ != 2'd0) ? skid0 : '0;
    credit   = {1'b0, occ} + {2'b00, inflight};
    issue    = (state == RUN) && !abort && (issued < cnt_r) &&
               (credit < (3'd2 + {2'b00, l0_wr}));
    sram_cen = !issue;
    sram_a   = issue ? (base_r + ADDR_W'(issued)) : '0;
  end

  assign sram_wen = 1'b1;

  // Two-entry skid: entry 0 is the head presented to L0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_r   <= '0;
      cnt_r    <= '0;
      issued   <= '0;
      written  <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      skid0    <= '0;
      skid1    <= '0;
    end else if (state == IDLE && start) begin
      base_r  <= base_addr;
      cnt_r   <= count;
      issued  <= '0;
      written <= '0;
    end else if (abort && (state == RUN || state == DRAIN)) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) issued  <= issued + CNT_W'(1);
      if (l0_wr) written <= written + CNT_W'(1);
      case ({inflight, l0_wr})
        2'b10: begin
          if (occ == 2'd0) skid0 <= sram_q;
          else             skid1 <= sram_q;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) skid0 <= sram_q;
          else begin
            skid0 <= skid1;
            skid1 <= sram_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ACT_LOAD_CHECKSUM_EN
  logic [W-1:0] sum_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     sum_r <= '0;
    else if (state == IDLE && start) sum_r <= '0;
    else if (l0_wr)                 sum_r <= sum_r ^ l0_in;
  end

  assign checksum = sum_r;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_act_load_ctrl.sv
// Self-checking bench for act_load_ctrl: queue-based reference model plus directed literal traces.
// Follows ACT_LOAD_CHECKSUM_EN for the expected checksum.
module tb_act_load_ctrl;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 12;
  localparam int W      = 32;
  localparam int DEPTH  = 2048;
`ifdef ACT_LOAD_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic              clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, l0_full = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  count = '0;
  logic              busy, done, sram_cen, sram_wen, l0_wr;
  logic [ADDR_W-1:0] sram_a;
  logic [W-1:0]      sram_q = '0, l0_in, checksum;
  logic [W-1:0]      mem [DEPTH];
  int                n_pass = 0, n_checks = 0;

  act_load_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .busy(busy), .done(done), .sram_cen(sram_cen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_q(sram_q), .l0_wr(l0_wr), .l0_in(l0_in), .l0_full(l0_full),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // One-cycle-latency SRAM read port
  always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_a];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the transfer seen as a word queue plus one pending read
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_t;
  mode_t        m_mode = M_IDLE;
  int           m_base = 0, m_cnt = 0, m_issued = 0, m_written = 0;
  logic [W-1:0] m_skid [$];
  bit           m_pend = 1'b0;
  logic [W-1:0] m_pend_data = '0;
  logic [W-1:0] m_sum = '0;

  always @(negedge clk) begin
    bit           pop, iss, old_pend;
    logic [W-1:0] head;
    int           addr;
    if (!reset) begin
      m_mode = M_IDLE; m_issued = 0; m_written = 0; m_skid.delete();
      m_pend = 1'b0; m_sum = '0;
    end
    pop  = (m_skid.size() > 0) && !l0_full;
    head = (m_skid.size() > 0) ? m_skid[0] : '0;
    iss  = (m_mode == M_RUN) && !abort && (m_issued < m_cnt) &&
           ((m_skid.size() + int'(m_pend) - int'(pop)) < 2);
    addr = (m_base + m_issued) % DEPTH;
    checkOutput("busy", 64'(busy), 64'(m_mode == M_RUN || m_mode == M_DRAIN));
    checkOutput("done", 64'(done), 64'(m_mode == M_DONE));
    checkOutput("l0_wr", 64'(l0_wr), 64'(pop));
    checkOutput("l0_in", 64'(l0_in), 64'(head));
    checkOutput("sram_wen", 64'(sram_wen), 64'(1));
    checkOutput("checksum", 64'(checksum), 64'(CHK_ON ? m_sum : '0));
    if (!(abort && m_mode == M_RUN)) begin
      checkOutput("sram_cen", 64'(sram_cen), 64'(!iss));
      checkOutput("sram_a", 64'(sram_a), iss ? 64'(addr) : 64'(0));
    end
    if (reset) begin
      old_pend = m_pend;
      case (m_mode)
        M_IDLE: if (start) begin
          m_base = int'(base_addr); m_cnt = int'(count); m_issued = 0; m_written = 0;
          m_sum = '0; m_skid.delete(); m_pend = 1'b0;
          m_mode = (count == '0) ? M_DONE : M_RUN;
        end
        M_RUN, M_DRAIN: begin
          if (pop) m_sum = m_sum ^ head;
          if (abort) begin
            m_skid.delete(); m_pend = 1'b0; m_mode = M_IDLE;
          end else begin
            if (pop) begin void'(m_skid.pop_front()); m_written++; end
            if (old_pend) m_skid.push_back(m_pend_data);
            m_pend = iss;
            if (iss) begin m_pend_data = mem[addr]; m_issued++; end
            if (m_mode == M_RUN && m_issued == m_cnt) m_mode = M_DRAIN;
            else if (m_mode == M_DRAIN && !old_pend && m_written == m_cnt) m_mode = M_DONE;
          end
        end
        M_DONE: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Per-cycle trace of one transfer; index = cycle number after the accepting edge
  bit                tr_wr [16], tr_done [16], tr_busy [16], tr_cen [16];
  logic [W-1:0]      tr_in [16], tr_sum [16];
  logic [ADDR_W-1:0] tr_a [16];

  task automatic applyStimulus(input int base, input int cnt, input int full_lo,
                               input int full_hi, input int abort_c, input int ncyc);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = ADDR_W'(base); count = CNT_W'(cnt); abort = 1'b0; l0_full = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      l0_full = (c >= full_lo) && (c <= full_hi);
      abort   = (c == abort_c);
      @(negedge clk);
      tr_wr[c] = l0_wr; tr_done[c] = done; tr_busy[c] = busy; tr_cen[c] = sram_cen;
      tr_in[c] = l0_in; tr_sum[c] = checksum; tr_a[c] = sram_a;
      @(posedge clk);
      #1;
    end
    abort = 1'b0; l0_full = 1'b0;
  endtask

  initial begin
    int                wr_seen;
    logic [ADDR_W-1:0] exp_a [4];
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    for (int k = 0; k < 16; k++) mem[k] = W'(k + 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // base 0, count 4, no backpressure
    applyStimulus(0, 4, 0, 0, 0, 9);
    for (int c = 1; c <= 9; c++) begin
      checkOutput("t1_wr", 64'(tr_wr[c]), 64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) checkOutput("t1_data", 64'(tr_in[c]), 64'(c - 2));
      checkOutput("t1_done", 64'(tr_done[c]), 64'(c == 7));
      checkOutput("t1_busy", 64'(tr_busy[c]), 64'(c <= 6));
    end
    checkOutput("t1_checksum", 64'(tr_sum[7]), CHK_ON ? 64'h4 : 64'h0);

    // Address wrap
    exp_a[0] = 11'd2046; exp_a[1] = 11'd2047; exp_a[2] = 11'd0; exp_a[3] = 11'd1;
    applyStimulus(2046, 4, 0, 0, 0, 8);
    for (int c = 1; c <= 4; c++) begin
      checkOutput("t2_cen", 64'(tr_cen[c]), 64'(0));
      checkOutput("t2_addr", 64'(tr_a[c]), 64'(exp_a[c-1]));
    end

    // Zero-length transfer
    applyStimulus(0, 0, 0, 0, 0, 4);
    for (int c = 1; c <= 4; c++) begin
      checkOutput("t3_done", 64'(tr_done[c]), 64'(c == 1));
      checkOutput("t3_cen", 64'(tr_cen[c]), 64'(1));
      checkOutput("t3_wr", 64'(tr_wr[c]), 64'(0));
      checkOutput("t3_busy", 64'(tr_busy[c]), 64'(0));
    end

    // Backpressure in cycles 4..7
    applyStimulus(0, 6, 4, 7, 0, 15);
    wr_seen = 0;
    for (int c = 1; c <= 15; c++) begin
      checkOutput("t4_wr", 64'(tr_wr[c]), 64'(c == 3 || (c >= 8 && c <= 12)));
      if (tr_wr[c]) begin
        wr_seen++;
        checkOutput("t4_data", 64'(tr_in[c]), 64'(wr_seen));
      end
      if (c >= 4 && c <= 7) checkOutput("t4_stall_cen", 64'(tr_cen[c]), 64'(1));
      checkOutput("t4_done", 64'(tr_done[c]), 64'(c == 13));
    end

    // Abort in cycle 5, then a short transfer
    applyStimulus(0, 8, 0, 0, 5, 10);
    for (int c = 1; c <= 10; c++) begin
      checkOutput("t5_done", 64'(tr_done[c]), 64'(0));
      checkOutput("t5_busy", 64'(tr_busy[c]), 64'(c <= 5));
      if (c >= 6) checkOutput("t5_wr", 64'(tr_wr[c]), 64'(0));
    end
    applyStimulus(0, 2, 0, 0, 0, 6);
    for (int c = 1; c <= 6; c++) begin
      checkOutput("t5b_wr", 64'(tr_wr[c]), 64'(c == 3 || c == 4));
      if (tr_wr[c]) checkOutput("t5b_data", 64'(tr_in[c]), 64'(c - 2));
      checkOutput("t5b_done", 64'(tr_done[c]), 64'(c == 5));
    end

    // Reset in cycle 4 of a count-8 transfer
    applyStimulus(0, 8, 0, 0, 0, 3);
    reset = 1'b0;
    #1;
    checkOutput("t6_busy", 64'(busy), 64'(0));
    checkOutput("t6_done", 64'(done), 64'(0));
    checkOutput("t6_cen", 64'(sram_cen), 64'(1));
    checkOutput("t6_addr", 64'(sram_a), 64'(0));
    checkOutput("t6_wr", 64'(l0_wr), 64'(0));
    checkOutput("t6_in", 64'(l0_in), 64'(0));
    checkOutput("t6_sum", 64'(checksum), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("t6_idle_wr", 64'(l0_wr), 64'(0));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      start     = ($urandom_range(0, 7) == 0);
      base_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      count     = ($urandom_range(0, 9) == 0) ? '0 : CNT_W'($urandom_range(1, 20));
      l0_full   = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 49) == 0);
      if (i == 1500) reset = 1'b0;
      if (i == 1502) reset = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; l0_full = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
